dffa_pipe: RTL and testbench
============================

Name: dffa_pipe

Overview:
- Parametrised successor to the single enabled D register used in the Huffman sort datapath.
- A DEPTH-stage, DATA_WIDTH-wide register pipeline with a valid/ready handshake at both ends, per-stage valid bits, bubble collapsing and synchronous flush.
- Sits between sort/merge stages so a stalled consumer back-pressures the producer without data loss or duplication.

Parameters:
- DATA_WIDTH, 4, width of each data word.
- DEPTH, 4, number of register stages; legal range is DEPTH >= 1.
- RESET_VALUE, 0, value loaded into every data register on reset or clear.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- clr  input  1  synchronous flush; active high.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  DATA_WIDTH  input word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  DATA_WIDTH  output word, taken from stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages, registered.

Behaviour:
- One clock domain. Reset is synchronous and active-low: the reset port is rst_n, sampled on the rising edge of clk.
- State per stage i (0..DEPTH-1):
  - vld[i]: valid bit.
  - dat[i]: data register.
  - Stage 0 is the input side; stage DEPTH-1 drives out_data and out_valid.
- Ready chain, combinational:
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !vld[i] || rdy[i+1].
  - in_ready = rdy[0] && !clr.
  - The out_ready to in_ready path is combinational by design.
- Stage update when rdy[i] = 1:
  - vld[i] <= source valid, where the source is vld[i-1], or in_valid for stage 0.
  - dat[i] <= source data only if the source is valid; otherwise dat[i] holds.
- Stage update when rdy[i] = 0: the stage holds both vld and dat.
- Transfer rules:
  - Input beat accepted when in_valid && in_ready.
  - Output beat retired when out_valid && out_ready.
- Latency:
  - Empty, unstalled pipeline: a word accepted on edge N appears on out_data after edge N+DEPTH-1, i.e. DEPTH-1 cycles after acceptance.
  - Throughput is 1 word/cycle when not back-pressured.
- Bubbles: an invalid stage always accepts from its predecessor, so gaps collapse under back-pressure. Full capacity is DEPTH words.
- count:
  - Increments on an accept without a retire.
  - Decrements on a retire without an accept.
  - Holds when both or neither occur.
  - Must always equal the popcount of vld.
- Word order is strictly FIFO; no loss and no duplication.
- Reset (rst_n=0) and clr=1 have identical effect, and both take priority over all transfers:
  - All vld cleared; all dat set to RESET_VALUE; count = 0.
  - While asserted: in_ready = 0 and out_valid = 0.
- Output values during reset and the following cycle: out_valid=0, out_data=RESET_VALUE, count=0, in_ready=1 (once rst_n and clr are both high).
- Full pipeline with out_ready=1 and in_valid=1: accept and retire in the same cycle; count is unchanged.
- Full pipeline with out_ready=0: in_ready=0 and in_data is ignored.
- out_data while out_valid=0 holds the last value; consumers must not use it.
- DEPTH=1 degenerates to a single register with ready = !vld || out_ready.

Decomposition:
- Shared package dffa_pkg holds:
  - Default DATA_WIDTH and DEPTH constants.
  - A count-width helper function, clog2(DEPTH+1).
- One natural sub-module, dffa_stage, generated DEPTH times:
  - Contents: one vld bit plus one dat register, with load = rdy[i] and a sync clear.
  - Inputs: src_valid, src_data, rdy_next.
  - Outputs: vld, dat, rdy.
- Top level contains the generate loop, the count register and the handshake gating.

Test Plan (DATA_WIDTH=4, DEPTH=4, RESET_VALUE=0):
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0 during reset. After release: out_valid=0, out_data=0, count=0, in_ready=1.
2. Streaming: out_ready=1; feed 1,2,3,...,8 back-to-back -> first out_valid 3 cycles after the first accept with out_data=1, then one word per cycle 2..8 in order. count reaches 4 and stays there while streaming.
3. Back-pressure: out_ready=0; offer A,B,C,D,E -> A..D accepted, in_ready=0 with E held, count=4. Raise out_ready -> outputs A,B,C,D,E in order with no loss or duplication; count returns to 0.
4. Bubble collapse: out_ready=0; push A, idle 2 cycles, push B -> A at stage 3, B at stage 2, count=2, in_ready=1, out_data=A.
5. Clear mid-stream: pipeline full (A..D), pulse clr for 1 cycle with in_valid=1 and in_data=F -> in_ready=0 during clr. Next cycle: count=0, out_valid=0, out_data=0; F is never output.
6. Full with simultaneous push/pop: full (1..4), out_ready=1, in_valid=1, in_data=5 -> in_ready=1, 1 retired, 5 accepted, count stays 4, next out_data=2.

Source files
------------

// File: rtl/dffa_pkg.sv
// Shared constants and helpers for the dffa_pipe register pipeline.
package dffa_pkg;

    localparam int unsigned DFFA_DATA_WIDTH = 4;
    localparam int unsigned DFFA_DEPTH      = 4;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int unsigned dffa_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffa_stage.sv
// One pipeline stage: a valid bit plus a data register, loaded whenever the stage is ready.
module dffa_stage
    import dffa_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH  = DFFA_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  rdy_next,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] dat,
    output logic                  rdy
);

    // An empty stage always accepts, which is what collapses bubbles.
    assign rdy = !vld || rdy_next;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            vld <= 1'b0;
            dat <= RESET_VALUE;
        end else if (rdy) begin
            vld <= src_valid;
            if (src_valid) begin
                dat <= src_data;
            end
        end
    end

endmodule

// File: rtl/dffa_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and occupancy count.
module dffa_pipe
    import dffa_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH  = DFFA_DATA_WIDTH,
    parameter int unsigned             DEPTH       = DFFA_DEPTH,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [dffa_cnt_width(DEPTH)-1:0]    count
);

    localparam int unsigned CW = dffa_cnt_width(DEPTH);

    logic [DEPTH:0]          rdy;
    logic [DEPTH-1:0]        vld;
    logic [DATA_WIDTH-1:0]   dat [DEPTH];
    logic                    flush;
    logic                    accept;
    logic                    retire;

    assign flush    = !rst_n || clr;
    assign rdy[DEPTH] = out_ready;

    // Stage 0 is fed by the producer, every later stage by its predecessor.
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        logic                  src_v;
        logic [DATA_WIDTH-1:0] src_d;

        if (i == 0) begin : g_head
            assign src_v = in_valid;
            assign src_d = in_data;
        end else begin : g_body
            assign src_v = vld[i-1];
            assign src_d = dat[i-1];
        end

        dffa_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .src_valid (src_v),
            .src_data  (src_d),
            .rdy_next  (rdy[i+1]),
            .vld       (vld[i]),
            .dat       (dat[i]),
            .rdy       (rdy[i])
        );
    end

    // Handshake is masked while flushing so nothing transfers during reset or clear.
    assign in_ready  = rdy[0] && !flush;
    assign out_valid = vld[DEPTH-1] && !flush;
    assign out_data  = dat[DEPTH-1];

    assign accept = in_valid && in_ready;
    assign retire = out_valid && out_ready;

    // Occupancy tracks accepts minus retires; equals the number of set valid bits.
    always_ff @(posedge clk) begin
        if (flush) begin
            count <= '0;
        end else if (accept && !retire) begin
            count <= count + CW'(1);
        end else if (retire && !accept) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_dffa_pipe.sv
// Self-checking bench for dffa_pipe against a queue-of-words position model.
module tb_dffa_pipe;

    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] RV  = '0;

    logic          clk = 1'b0;
    logic          rst_n, clr, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    dffa_pipe #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    // Model: words in flight with their stage position (DEPTH-1 = output side).
    typedef struct {
        logic [DW-1:0] d;
        int            p;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] last_out = RV;
    logic          exp_in_ready, exp_out_valid;
    logic [DW-1:0] exp_out_data;
    logic [CW-1:0] exp_count;

    task automatic model_eval();
        logic full;
        full          = (q.size() == int'(DEPTH));
        exp_in_ready  = rst_n && !clr && !(full && !out_ready);
        exp_out_valid = rst_n && !clr && (q.size() > 0) && (q[0].p == int'(DEPTH) - 1);
        exp_out_data  = last_out;
        exp_count     = CW'(q.size());
    endtask

    task automatic drive(input logic r, input logic c, input logic iv,
                         input logic [DW-1:0] d, input logic ordy);
        rst_n = r; clr = c; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        model_eval();
    endtask

    // Each word advances one position unless the word ahead of it blocks.
    task automatic advance();
        ent_t nq[$];
        int   lim;
        int   np;
        if (!rst_n || clr) begin
            q.delete();
            last_out = RV;
        end else begin
            lim = int'(DEPTH) - 1;
            foreach (q[k]) begin
                if (k == 0 && exp_out_valid && out_ready) continue;
                np = (q[k].p + 1 < lim) ? q[k].p + 1 : lim;
                if (np == int'(DEPTH) - 1 && q[k].p != int'(DEPTH) - 1) last_out = q[k].d;
                nq.push_back('{d: q[k].d, p: np});
                lim = np - 1;
            end
            if (in_valid && exp_in_ready) begin
                nq.push_back('{d: in_data, p: 0});
                if (DEPTH == 1) last_out = in_data;
            end
            q = nq;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush_pipe();
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready0 got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid0 got %0b exp 0", out_valid); end
        advance();
        drive(1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready1 got %0b exp 0", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        advance();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL post_reset_out_data got %0h exp 0", out_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL post_reset_count got %0d exp 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b exp 1", in_ready); end
        advance();
    endtask

    task automatic test_stream();
        logic [DW-1:0] got[$];
        int nxt = 1;
        int acc_cyc = -1;
        int first_out = -1;
        logic iv;
        flush_pipe();
        for (int cyc = 0; cyc < 20; cyc++) begin
            iv = (nxt <= 8);
            drive(1'b1, 1'b0, iv, DW'(nxt), 1'b1);
            checks++; if (in_ready !== exp_in_ready) begin errors++; $display("FAIL stream_in_ready cyc %0d got %0b exp %0b", cyc, in_ready, exp_in_ready); end
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL stream_out_valid cyc %0d got %0b exp %0b", cyc, out_valid, exp_out_valid); end
            checks++; if (out_data !== exp_out_data) begin errors++; $display("FAIL stream_out_data cyc %0d got %0h exp %0h", cyc, out_data, exp_out_data); end
            if (cyc >= 4 && cyc <= 8) begin
                checks++; if (count !== 3'd4) begin errors++; $display("FAIL stream_count cyc %0d got %0d exp 4", cyc, count); end
            end
            if (out_valid) begin
                got.push_back(out_data);
                if (first_out < 0) first_out = cyc;
            end
            if (iv && in_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                nxt++;
            end
            advance();
        end
        // The accepting edge ends cycle acc_cyc; the word is visible DEPTH-1 edges later.
        checks++; if (first_out !== acc_cyc + int'(DEPTH)) begin errors++; $display("FAIL stream_latency got %0d exp %0d", first_out - acc_cyc, DEPTH); end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL stream_words got %0d exp 8", got.size()); end
        foreach (got[k]) begin
            checks++; if (got[k] !== DW'(k + 1)) begin errors++; $display("FAIL stream_order idx %0d got %0h exp %0h", k, got[k], k + 1); end
        end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] items [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        logic [DW-1:0] got[$];
        int idx = 0;
        flush_pipe();
        for (int cyc = 0; cyc < 5; cyc++) begin
            drive(1'b1, 1'b0, 1'b1, items[idx], 1'b0);
            checks++; if (in_ready !== exp_in_ready) begin errors++; $display("FAIL bp_in_ready cyc %0d got %0b exp %0b", cyc, in_ready, exp_in_ready); end
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL bp_out_valid cyc %0d got %0b exp %0b", cyc, out_valid, exp_out_valid); end
            if (in_ready && idx < 4) idx++;
            if (cyc < 4) advance();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %0b exp 0", in_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d exp 4", count); end
        checks++; if (idx !== 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", idx); end
        advance();
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(1'b1, 1'b0, idx < 5, items[idx < 5 ? idx : 4], 1'b1);
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL bp_drain_valid cyc %0d got %0b exp %0b", cyc, out_valid, exp_out_valid); end
            checks++; if (count !== exp_count) begin errors++; $display("FAIL bp_drain_count cyc %0d got %0d exp %0d", cyc, count, exp_count); end
            if (out_valid) got.push_back(out_data);
            if (idx < 5 && in_ready) idx++;
            advance();
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_words got %0d exp 5", got.size()); end
        foreach (got[k]) begin
            if (k < 5) begin
                checks++; if (got[k] !== items[k]) begin errors++; $display("FAIL bp_order idx %0d got %0h exp %0h", k, got[k], items[k]); end
            end
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_final_count got %0d exp 0", count); end
        advance();
    endtask

    task automatic test_bubble();
        logic [DW-1:0] seq_v [6] = '{4'h6, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0};
        logic          seq_i [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        flush_pipe();
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(1'b1, 1'b0, seq_i[cyc], seq_v[cyc], 1'b0);
            checks++; if (count !== exp_count) begin errors++; $display("FAIL bubble_count cyc %0d got %0d exp %0d", cyc, count, exp_count); end
            checks++; if (out_data !== exp_out_data) begin errors++; $display("FAIL bubble_out_data cyc %0d got %0h exp %0h", cyc, out_data, exp_out_data); end
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL bubble_final_count got %0d exp 2", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_data !== 4'h6) begin errors++; $display("FAIL bubble_out_data got %0h exp 6", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bubble_out_valid got %0b exp 1", out_valid); end
        advance();
    endtask

    task automatic test_clear();
        flush_pipe();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, DW'(4'hA + k), 1'b0);
            advance();
        end
        drive(1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid got %0b exp 0", out_valid); end
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_after_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL clr_out_data got %0h exp 0", out_data); end
        advance();
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_leak cyc %0d got %0b exp 0", cyc, out_valid); end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        flush_pipe();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, DW'(k), 1'b0);
            advance();
        end
        drive(1'b1, 1'b0, 1'b1, 4'h5, 1'b1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %0b exp 1", out_valid); end
        checks++; if (out_data !== 4'h1) begin errors++; $display("FAIL b2b_out_data got %0h exp 1", out_data); end
        advance();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", count); end
        checks++; if (out_data !== 4'h2) begin errors++; $display("FAIL b2b_next_data got %0h exp 2", out_data); end
        advance();
    endtask

    task automatic test_random();
        logic c, iv, ordy;
        flush_pipe();
        for (int cyc = 0; cyc < 400; cyc++) begin
            c    = ($urandom_range(0, 31) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            drive(1'b1, c, iv, DW'($urandom), ordy);
            checks++; if (in_ready !== exp_in_ready) begin errors++; $display("FAIL rand_in_ready cyc %0d got %0b exp %0b", cyc, in_ready, exp_in_ready); end
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL rand_out_valid cyc %0d got %0b exp %0b", cyc, out_valid, exp_out_valid); end
            checks++; if (out_data !== exp_out_data) begin errors++; $display("FAIL rand_out_data cyc %0d got %0h exp %0h", cyc, out_data, exp_out_data); end
            checks++; if (count !== exp_count) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", cyc, count, exp_count); end
            advance();
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_back_pressure();
        test_bubble();
        test_clear();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
